// File: rtl/snek_pkg.sv
// Shared definitions for the snake game controller.
// Contents: direction codes, grid size, game state enum, and a helper that
// tells whether two directions point opposite ways.
package snek_pkg;

  localparam logic [2:0] DIR_LEFT  = 3'd0;
  localparam logic [2:0] DIR_RIGHT = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_UP    = 3'd3;
  localparam logic [2:0] DIR_STOP  = 3'd4;

  localparam int unsigned GRID_W = 32;
  localparam int unsigned GRID_H = 24;

  typedef enum logic [1:0] {
    SPLASH = 2'd0,
    RUN    = 2'd1,
    OVER   = 2'd2
  } state_t;

  // Opposite pairs are 0/1 and 2/3: same bit 1, different bit 0. STOP has no opposite.
  function automatic logic is_opposite(input logic [2:0] a, input logic [2:0] b);
    return !a[2] && !b[2] && (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snek_lfsr.sv
// 16-bit Galois LFSR (taps 16,14,13,11) used as the food position source.
// Ports:
//   frame_clk  clock, state on posedge
//   rst        synchronous active-high reset, loads SEED
//   en         advance one step this cycle
//   state      current LFSR contents
module snek_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        frame_clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] state
);

  logic [15:0] state_d;

  always_comb begin
    state_d = state;
    if (en) begin
      state_d = {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge frame_clk) begin
    if (rst) begin
      state <= SEED;
    end else begin
      state <= state_d;
    end
  end

endmodule

// File: rtl/snek_ctrl.sv
// Game-side controller for the snake generator: button decode to dir, game
// sequencing (splash/run/over), food placement, eat detection, grow pulses, score.
// Ports:
//   frame_clk, rst                 clock (one tick per game step), sync active-high reset
//   btn_left/right/down/up/start   player buttons, level
//   head_h, head_v, dead           snake head cell and collision flag
//   hpos, vpos                     pixel being drawn
//   dir                            0=left 1=right 2=down 3=up 4=stopped
//   run, snek_rst                  snake may move / hold snake generator in reset
//   grow_flag                      one-cycle grow pulse
//   food_h, food_v, food_loc       food cell and pixel-inside-food flag
//   score                          foods eaten this game (saturating)
//   hiscore                        best score since reset (only with SNEK_HISCORE_EN defined)
module snek_ctrl
  import snek_pkg::*;
#(
  parameter int unsigned MAX_GROW  = 15,
  parameter int unsigned CELL_PX   = 20,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       frame_clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_up,
  input  logic       btn_start,
  input  logic [5:0] head_h,
  input  logic [5:0] head_v,
  input  logic       dead,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  output logic [2:0] dir,
  output logic       run,
  output logic       snek_rst,
  output logic       grow_flag,
  output logic [5:0] food_h,
  output logic [5:0] food_v,
  output logic       food_loc,
  output logic [7:0] score
`ifdef SNEK_HISCORE_EN
  ,
  output logic [7:0] hiscore
`endif
);

  localparam int unsigned GrowW   = (MAX_GROW > 0) ? $clog2(MAX_GROW + 1) : 1;
  localparam logic [GrowW-1:0] GrowMax = GrowW'(MAX_GROW);
  localparam logic [10:0] CellPx  = 11'(CELL_PX);

  state_t           state_q, state_d;
  logic             start_q;
  logic [2:0]       dir_q, dir_d;
  logic             grow_q, grow_d;
  logic [7:0]       score_q, score_d;
  logic [5:0]       food_h_q, food_h_d, food_v_q, food_v_d;
  logic             pending_q, pending_d;
  logic [GrowW-1:0] grow_cnt_q, grow_cnt_d;

  logic [15:0] lfsr;
  logic        unused_lfsr;

  snek_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .frame_clk(frame_clk),
    .rst      (rst),
    .en       (1'b1),
    .state    (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:10];

  logic       start_rise, eat, cand_ok, req_valid;
  logic [2:0] req;
  logic [5:0] cand_h, cand_v;

  always_comb begin
    start_rise = btn_start & ~start_q;
    eat = (state_q == RUN) && !dead && !pending_q &&
          (head_h == food_h_q) && (head_v == food_v_q);

    // Rows past the grid fold back by 8 so every candidate is on screen.
    cand_h  = {1'b0, lfsr[4:0]};
    cand_v  = (lfsr[9:5] >= 5'(GRID_H)) ? {1'b0, lfsr[9:5] - 5'd8} : {1'b0, lfsr[9:5]};
    cand_ok = !((cand_h == head_h) && (cand_v == head_v));

    req_valid = 1'b1;
    if (btn_left)       req = DIR_LEFT;
    else if (btn_right) req = DIR_RIGHT;
    else if (btn_down)  req = DIR_DOWN;
    else if (btn_up)    req = DIR_UP;
    else begin
      req       = DIR_STOP;
      req_valid = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    grow_d     = 1'b0;
    score_d    = score_q;
    food_h_d   = food_h_q;
    food_v_d   = food_v_q;
    pending_d  = pending_q;
    grow_cnt_d = grow_cnt_q;

    // Respawn in any state until a candidate not under the head appears.
    if (pending_q && cand_ok) begin
      food_h_d  = cand_h;
      food_v_d  = cand_v;
      pending_d = 1'b0;
    end

    unique case (state_q)
      SPLASH: begin
        dir_d      = DIR_STOP;
        score_d    = 8'd0;
        grow_cnt_d = '0;
        if (start_rise) state_d = RUN;
      end
      RUN: begin
        if (req_valid && !is_opposite(req, dir_q)) dir_d = req;
        if (dead) state_d = OVER;
        if (eat) begin
          pending_d = 1'b1;
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
          if (grow_cnt_q < GrowMax) begin
            grow_d     = 1'b1;
            grow_cnt_d = grow_cnt_q + GrowW'(1);
          end
        end
      end
      OVER: begin
        if (start_rise) state_d = SPLASH;
      end
      default: state_d = SPLASH;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (rst) begin
      state_q    <= SPLASH;
      start_q    <= 1'b0;
      dir_q      <= DIR_STOP;
      grow_q     <= 1'b0;
      score_q    <= 8'd0;
      food_h_q   <= 6'd7;
      food_v_q   <= 6'd5;
      pending_q  <= 1'b0;
      grow_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= btn_start;
      dir_q      <= dir_d;
      grow_q     <= grow_d;
      score_q    <= score_d;
      food_h_q   <= food_h_d;
      food_v_q   <= food_v_d;
      pending_q  <= pending_d;
      grow_cnt_q <= grow_cnt_d;
    end
  end

`ifdef SNEK_HISCORE_EN
  logic [7:0] hiscore_q;

  always_ff @(posedge frame_clk) begin
    if (rst) begin
      hiscore_q <= 8'd0;
    end else if ((state_q == RUN) && (state_d == OVER) && (score_q > hiscore_q)) begin
      hiscore_q <= score_q;
    end
  end

  assign hiscore = hiscore_q;
`endif

  // Strict bounds leave a 1-px border, matching how snake cells are drawn.
  logic [10:0] x0, x1, y0, y1;

  always_comb begin
    x0 = 11'(food_h_q) * CellPx;
    x1 = x0 + CellPx;
    y0 = 11'(food_v_q) * CellPx;
    y1 = y0 + CellPx;
    food_loc = !pending_q &&
               ({1'b0, hpos} > x0) && ({1'b0, hpos} < x1) &&
               ({1'b0, vpos} > y0) && ({1'b0, vpos} < y1);
  end

  assign dir       = dir_q;
  assign run       = (state_q == RUN);
  assign snek_rst  = (state_q == SPLASH);
  assign grow_flag = grow_q;
  assign food_h    = food_h_q;
  assign food_v    = food_v_q;
  assign score     = score_q;

endmodule
